// File: rtl/gb_alu_seq.sv
// Sequential CPU ALU: W-bit operands processed SLICE_W bits per cycle, LSB slice first.
// Define GB_ALU_SEQ_ROT_EN to build the rotate/shift ops (A-F); otherwise they report out_err.
module gb_alu_seq #(
  parameter int unsigned W       = 8,
  parameter int unsigned SLICE_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [3:0]   in_flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [3:0]   out_flags,
  output logic         out_err
);

  localparam int unsigned N    = W / SLICE_W;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(N - 1);

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpAdc = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpSbc = 4'h3;
  localparam logic [3:0] OpAnd = 4'h4;
  localparam logic [3:0] OpOr  = 4'h5;
  localparam logic [3:0] OpXor = 4'h6;
  localparam logic [3:0] OpCp  = 4'h7;
  localparam logic [3:0] OpInc = 4'h8;
  localparam logic [3:0] OpDec = 4'h9;
`ifdef GB_ALU_SEQ_ROT_EN
  localparam logic [3:0] OpRlc = 4'hA;
  localparam logic [3:0] OpRl  = 4'hB;
  localparam logic [3:0] OpRrc = 4'hC;
  localparam logic [3:0] OpRr  = 4'hD;
  localparam logic [3:0] OpSla = 4'hE;
  localparam logic [3:0] OpSrl = 4'hF;
`endif

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d, flags_q, flags_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic            carry_q, carry_d, zero_q, zero_d;
  logic [CntW-1:0] idx_q, idx_d;
  logic [W-1:0]    out_result_q, out_result_d;
  logic [3:0]      out_flags_q, out_flags_d;
  logic            out_err_q, out_err_d;

  logic               accept, is_sub, is_arith, first_cin, cin, h_raw, c_arith;
  logic [SLICE_W-1:0] a_sl, b_sl;
  logic [SLICE_W:0]   sum;
  logic               zero_acc;
  logic [W-1:0]       a_rot, b_rot, res_shift;
  logic [3:0]         arith_flags;
  logic [W-1:0]       sp_result;
  logic               sp_h, sp_c, sp_err;
  logic [3:0]         sp_flags;

  assign in_ready   = ~rst & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state_q == StDone);
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign out_err    = out_err_q;

  assign is_sub   = (op_q == OpSub) | (op_q == OpSbc) | (op_q == OpCp) | (op_q == OpDec);
  assign is_arith = (op_q <= OpSbc) | (op_q == OpCp) | (op_q == OpInc) | (op_q == OpDec);

  always_comb begin
    case (op_q)
      OpAdc:              first_cin = flags_q[0];
      OpSub, OpCp, OpDec: first_cin = 1'b1;
      OpSbc:              first_cin = ~flags_q[0];
      default:            first_cin = 1'b0;
    endcase
  end

  // Subtraction runs as A + ~B + ~borrow; carries are inverted back into borrows for the flags.
  assign a_sl      = a_q[SLICE_W-1:0];
  assign b_sl      = b_q[SLICE_W-1:0] ^ {SLICE_W{is_sub}};
  assign cin       = (idx_q == '0) ? first_cin : carry_q;
  assign sum       = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, cin};
  assign zero_acc  = zero_q & (sum[SLICE_W-1:0] == '0);
  assign h_raw     = sum[SLICE_W-4] ^ a_sl[SLICE_W-4] ^ b_sl[SLICE_W-4];
  assign c_arith   = ((op_q == OpInc) | (op_q == OpDec)) ? flags_q[0] : (sum[SLICE_W] ^ is_sub);
  assign arith_flags = {zero_acc, is_sub, h_raw ^ is_sub, c_arith};

  // Operands rotate so the original A is back in place after the last slice (needed by CP).
  assign a_rot     = (a_q >> SLICE_W) | (a_q << (W - SLICE_W));
  assign b_rot     = (b_q >> SLICE_W) | (b_q << (W - SLICE_W));
  assign res_shift = (res_q >> SLICE_W) | (W'(sum[SLICE_W-1:0]) << (W - SLICE_W));

  always_comb begin
    sp_result = '0;
    sp_h      = 1'b0;
    sp_c      = 1'b0;
    sp_err    = 1'b0;
    case (op_q)
      OpAnd: begin
        sp_result = a_q & b_q;
        sp_h      = 1'b1;
      end
      OpOr:  sp_result = a_q | b_q;
      OpXor: sp_result = a_q ^ b_q;
`ifdef GB_ALU_SEQ_ROT_EN
      OpRlc: begin sp_result = {a_q[W-2:0], a_q[W-1]};      sp_c = a_q[W-1]; end
      OpRl:  begin sp_result = {a_q[W-2:0], flags_q[0]};    sp_c = a_q[W-1]; end
      OpRrc: begin sp_result = {a_q[0], a_q[W-1:1]};        sp_c = a_q[0];   end
      OpRr:  begin sp_result = {flags_q[0], a_q[W-1:1]};    sp_c = a_q[0];   end
      OpSla: begin sp_result = {a_q[W-2:0], 1'b0};          sp_c = a_q[W-1]; end
      OpSrl: begin sp_result = {1'b0, a_q[W-1:1]};          sp_c = a_q[0];   end
`endif
      default: sp_err = 1'b1;
    endcase
    sp_flags = sp_err ? flags_q : {(sp_result == '0), 1'b0, sp_h, sp_c};
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    flags_d      = flags_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    idx_d        = idx_q;
    res_d        = res_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    out_err_d    = out_err_q;
    case (state_q)
      StIdle, StDone: begin
        if ((state_q == StDone) && out_ready) state_d = StIdle;
        if (accept) begin
          state_d = StBusy;
          op_d    = in_op;
          a_d     = in_a;
          b_d     = ((in_op == OpInc) || (in_op == OpDec)) ? W'(1) : in_b;
          flags_d = in_flags;
          idx_d   = '0;
          zero_d  = 1'b1;
        end
      end
      StBusy: begin
        if (is_arith) begin
          a_d     = a_rot;
          b_d     = b_rot;
          carry_d = sum[SLICE_W];
          zero_d  = zero_acc;
          res_d   = res_shift;
          idx_d   = idx_q + CntW'(1);
          if (idx_q == LastIdx) begin
            state_d      = StDone;
            out_result_d = (op_q == OpCp) ? a_rot : res_shift;
            out_flags_d  = arith_flags;
            out_err_d    = 1'b0;
          end
        end else begin
          // Logic, rotate and unsupported ops finish in a single BUSY cycle.
          state_d      = StDone;
          out_result_d = sp_result;
          out_flags_d  = sp_flags;
          out_err_d    = sp_err;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      flags_q      <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      idx_q        <= '0;
      res_q        <= '0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      flags_q      <= flags_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
      idx_q        <= idx_d;
      res_q        <= res_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      out_err_q    <= out_err_d;
    end
  end

endmodule
